// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder
// Description : Digit-serial WIDTH-bit adder/subtractor, DIGIT bits per clock,
//               LSB digit first, with start/busy/done handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int STEPS = WIDTH / DIGIT;
    localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(STEPS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_carry;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_shift;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;

    logic [DIGIT:0]   w_digit_sum;
    logic [DIGIT-1:0] w_digit;
    logic             w_carry_out;
    logic             w_carry_msb;
    logic [WIDTH-1:0] w_shift_next;

    assign w_digit_sum = {1'b0, r_a[DIGIT-1:0]} + {1'b0, r_b[DIGIT-1:0]}
                       + {{DIGIT{1'b0}}, r_carry};
    assign w_digit     = w_digit_sum[DIGIT-1:0];
    assign w_carry_out = w_digit_sum[DIGIT];
    // Carry into the digit MSB recovered from its sum bit: s = a ^ b ^ c_in.
    assign w_carry_msb = r_a[DIGIT-1] ^ r_b[DIGIT-1] ^ w_digit[DIGIT-1];

    generate
        if (DIGIT == WIDTH) begin : g_single_step
            assign w_shift_next = w_digit;
        end else begin : g_multi_step
            assign w_shift_next = {w_digit, r_shift[WIDTH-1:DIGIT]};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_shift <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_a     <= a;
                        r_b     <= sub ? ~b : b;
                        r_carry <= cin ^ sub;
                        r_cnt   <= '0;
                        r_shift <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_a     <= r_a >> DIGIT;
                    r_b     <= r_b >> DIGIT;
                    r_carry <= w_carry_out;
                    r_shift <= w_shift_next;
                    if (r_cnt == C_LAST) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_sum   <= w_shift_next;
                        r_cout  <= w_carry_out;
                        r_ovf   <= w_carry_msb ^ w_carry_out;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign sum      = r_sum;
    assign cout     = r_cout;
    assign overflow = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_adder
// Description : Self-checking bench for serial_adder (8-bit and 4-bit variants)
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_adder;

    logic clk;
    logic rst_n;

    logic       start8, cin8, sub8;
    logic [7:0] a8, b8;
    logic       busy8, done8, cout8, ov8;
    logic [7:0] sum8;

    logic       start4 [3];
    logic [3:0] a4, b4;
    logic       cin4, sub4;
    logic       busy4 [3];
    logic       done4 [3];
    logic       cout4 [3];
    logic       ov4   [3];
    logic [3:0] sum4  [3];

    int checks = 0;
    int errors = 0;

    serial_adder #(.WIDTH(8), .DIGIT(1)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
        .cin(cin8), .sub(sub8), .busy(busy8), .done(done8),
        .sum(sum8), .cout(cout8), .overflow(ov8)
    );

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut4
        serial_adder #(.WIDTH(4), .DIGIT(1 << gi)) u_dut (
            .clk(clk), .rst_n(rst_n), .start(start4[gi]), .a(a4), .b(b4),
            .cin(cin4), .sub(sub4), .busy(busy4[gi]), .done(done4[gi]),
            .sum(sum4[gi]), .cout(cout4[gi]), .overflow(ov4[gi])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: integer arithmetic on unsigned and signed interpretations.
    // Returns {overflow, cout, sum[7:0]} with sum masked to w bits.
    function automatic logic [9:0] model(input int w, input int a, input int b,
                                         input bit ci, input bit su);
        int ua, ub, sa, sb, u, s, mask;
        logic co, ov;
        logic [7:0] sm;
        mask = (1 << w) - 1;
        ua = a & mask;
        ub = b & mask;
        sa = (ua >= (1 << (w - 1))) ? ua - (1 << w) : ua;
        sb = (ub >= (1 << (w - 1))) ? ub - (1 << w) : ub;
        if (!su) begin
            u  = ua + ub + int'(ci);
            s  = sa + sb + int'(ci);
            co = (u >= (1 << w));
        end else begin
            u  = ua - ub - int'(ci);
            s  = sa - sb - int'(ci);
            co = (u >= 0);
        end
        ov = (s < -(1 << (w - 1))) || (s > (1 << (w - 1)) - 1);
        sm = 8'(u & mask);
        return {ov, co, sm};
    endfunction

    task automatic op8(input logic [7:0] a, input logic [7:0] b,
                       input bit ci, input bit su, input bit pulse);
        logic [9:0] e;
        logic [7:0] prev;
        e = model(8, int'(a), int'(b), ci, su);
        @(negedge clk);
        a8 = a; b8 = b; cin8 = ci; sub8 = su; start8 = 1'b1;
        prev = sum8;
        @(posedge clk); #1;
        check("w8_accept_busy", {busy8, done8}, 2'b10);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            start8 = pulse && (k == 3 || k == 8);
            a8 = 8'($urandom); b8 = 8'($urandom);
            cin8 = 1'($urandom); sub8 = 1'($urandom);
            @(posedge clk); #1;
            if (k < 8) begin
                check("w8_run_busy", {busy8, done8}, 2'b10);
                check("w8_sum_hold", sum8, prev);
            end else begin
                check("w8_done", {busy8, done8}, 2'b01);
                check("w8_result", {ov8, cout8, sum8}, e);
            end
        end
        @(negedge clk);
        start8 = 1'b0;
        @(posedge clk); #1;
        check("w8_after_done", {busy8, done8}, 2'b00);
        check("w8_result_hold", {ov8, cout8, sum8}, e);
    endtask

    task automatic run4(input int d, input int steps);
        logic [9:0] v;
        logic [9:0] e;
        int n;
        @(negedge clk);
        v = 10'd0;
        a4 = v[3:0]; b4 = v[7:4]; cin4 = v[8]; sub4 = v[9];
        start4[d] = 1'b1;
        for (int idx = 0; idx < 1024; idx++) begin
            v = 10'(idx);
            e = model(4, int'(v[3:0]), int'(v[7:4]), v[8], v[9]);
            @(posedge clk); #1;
            check("w4_accept_busy", {busy4[d], done4[d]}, 2'b10);
            @(negedge clk);
            v = 10'(idx + 1);
            a4 = v[3:0]; b4 = v[7:4]; cin4 = v[8]; sub4 = v[9];
            n = 0;
            while (n < steps + 4 && done4[d] !== 1'b1) begin
                @(posedge clk); #1;
                n++;
            end
            check("w4_latency", n, steps);
            check("w4_result", {ov4[d], cout4[d], 4'h0, sum4[d]}, e);
            @(posedge clk); #1;
            check("w4_idle", {busy4[d], done4[d]}, 2'b00);
        end
        @(negedge clk);
        start4[d] = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        logic seen;
        rst_n = 1'b0;
        start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0; sub8 = 1'b0;
        a4 = '0; b4 = '0; cin4 = 1'b0; sub4 = 1'b0;
        for (int i = 0; i < 3; i++) start4[i] = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_w8", {busy8, done8, ov8, cout8, sum8}, 12'h000);
        for (int i = 0; i < 3; i++)
            check("rst_w4", {busy4[i], done4[i], ov4[i], cout4[i], sum4[i]}, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases
        op8(8'h5A, 8'h3C, 1'b0, 1'b0, 1'b0);
        op8(8'hFF, 8'h00, 1'b1, 1'b0, 1'b0);
        op8(8'h80, 8'h01, 1'b0, 1'b1, 1'b0);
        check("tp_80m01", {ov8, cout8, sum8}, 10'h37F);
        op8(8'h10, 8'h20, 1'b0, 1'b1, 1'b0);
        check("tp_10m20", {ov8, cout8, sum8}, 10'h0F0);
        op8(8'h05, 8'h05, 1'b1, 1'b1, 1'b0);
        check("tp_05m05", {cout8, sum8}, 9'h0FF);
        op8(8'h5A, 8'h3C, 1'b0, 1'b0, 1'b1);
        check("tp_5Ap3C", {ov8, cout8, sum8}, 10'h296);

        // Reset aborts a run mid-flight
        @(negedge clk);
        a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0; sub8 = 1'b0; start8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("rst_mid_busy", {busy8, done8}, 2'b00);
        check("rst_mid_result", {ov8, cout8, sum8}, 10'h000);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            seen = seen | done8 | busy8;
        end
        check("rst_no_done", seen, 1'b0);
        op8(8'hC3, 8'h4E, 1'b1, 1'b1, 1'b0);

        // Randomized operations, some with ignored start pulses mid-run
        for (int i = 0; i < 40; i++)
            op8(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));

        // Exhaustive 4-bit sweeps, start held high back-to-back
        run4(0, 4);
        run4(1, 2);
        run4(2, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/serial_adder.md
# serial_adder

Parametrised multi-cycle adder/subtractor, successor to the single-bit combinational full adder. It processes two WIDTH-bit operands DIGIT bits per clock, LSB digit first, through one DIGIT-bit ripple slice and a carry register. A start/busy/done handshake wraps each operation. It serves area-constrained datapaths where WIDTH-bit arithmetic can take WIDTH/DIGIT+1 cycles.

## Interface
Parameters:
- WIDTH, 8, operand and result width in bits; must be ≥ 2.
- DIGIT, 1, bits processed per cycle; must divide WIDTH. STEPS = WIDTH/DIGIT.

Ports:
- clk  input  1  rising-edge clock; the block uses only this clock.
- rst_n  input  1  reset, synchronous and active-low.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  operand A; captured on the accepting edge.
- b  input  WIDTH  operand B; captured on the accepting edge.
- cin  input  1  carry-in (add) or borrow-in (sub); captured on the accepting edge.
- sub  input  1  0 = add, 1 = subtract; captured on the accepting edge.
- busy  output  1  high while the operation is in progress (RUN).
- done  output  1  one-cycle pulse; results are valid from this cycle onward.
- sum  output  WIDTH  result.
- cout  output  1  carry-out. In sub mode, 1 = no borrow.
- overflow  output  1  two's-complement signed overflow of the result.

## Operation
- States: IDLE, RUN, DONE.
- IDLE → RUN on a clk edge with rst_n=1 and start=1. On that edge the block:
  - latches a;
  - latches b, or ~b when sub=1;
  - loads the carry register with cin when sub=0, or ~cin when sub=1;
  - clears the step counter and the internal shift register.
- Subtract therefore computes a − b − cin as a + ~b + ~cin.
- RUN: each edge adds the current low DIGIT bits of A, B and the carry register. The result digit shifts into the internal result register from the MSB end. A and B shift right by DIGIT. The counter increments.
- On the edge where the counter reaches STEPS−1, the state moves RUN → DONE. On that same edge:
  - sum gets the completed result;
  - cout gets the final carry;
  - overflow gets the carry into bit WIDTH−1 XOR the carry out of bit WIDTH−1. This is computed within the last digit slice.
- DONE → IDLE unconditionally on the next edge.
- start is ignored in RUN and DONE. Requests are not queued.
- sum, cout and overflow update only on the completion edge. They hold their values until the next completion or reset. The internal shift register is never visible on the outputs.
- The a, b, cin and sub inputs may change freely after the accepting edge without affecting the operation in flight.

## Timing
- Reset (rst_n=0 at an edge) has priority over every other event:
  - state becomes IDLE;
  - busy=0, done=0, sum=0, cout=0, overflow=0;
  - counter, carry and operand registers are cleared.
- Reset asserted mid-RUN aborts the operation. No done pulse follows.
- Let edge 0 be the accepting edge:
  - busy=1 after edges 0..STEPS−1;
  - busy=0 after edge STEPS, together with done=1 and valid results;
  - done=0 after edge STEPS+1, with the state back in IDLE.
- Latency from the accepting edge to done is STEPS edges. Minimum start-to-start spacing is STEPS+2 cycles.
- busy and done are never high together.
- start held high continuously is accepted once per STEPS+2 cycles: on each edge where the state is IDLE.
- Boundary cases:
  - DIGIT=WIDTH gives STEPS=1, so RUN lasts one cycle.
  - The counter width is $clog2(STEPS) with a minimum of 1 bit. The counter never wraps within an operation.

## Test plan
- WIDTH=8, DIGIT=1, add 8'h5A + 8'h3C, cin=0 → done 8 edges after acceptance; sum=8'h96, cout=0, overflow=1. busy is high for exactly 8 cycles.
- Add 8'hFF + 8'h00, cin=1 → sum=8'h00, cout=1, overflow=0. Then sub 8'h80 − 8'h01, cin=0 → sum=8'h7F, cout=1, overflow=1.
- Sub 8'h10 − 8'h20, cin=0 → sum=8'hF0, cout=0, overflow=0. Sub 8'h05 − 8'h05, cin=1 → sum=8'hFF, cout=0.
- Pulse start again at edges 3 and 8 of a run, with a and b changed → both ignored. Results match the original operands, and the previous sum holds until the completion edge.
- Deassert rst_n at edge 4 of a run → the next cycle shows busy=0, sum=0, and no done pulse. A fresh start afterwards completes correctly.
- WIDTH=4 with DIGIT ∈ {1, 2, 4}: exhaustive a, b, cin, sub against a golden model. Latency must be 4, 2 and 1 respectively, with start held high for back-to-back operations.
